// File: rtl/vib_pkg.sv
// Shared types and defaults for the vibration window controller.
package vib_pkg;

   localparam int VIB_WIN_LEN_DEF = 256;
   localparam int VIB_DW_DEF      = 16;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_FIRST   = 2'd1,
      ST_COLLECT = 2'd2,
      ST_REPORT  = 2'd3
   } vib_state_e;

endpackage

// File: rtl/vib_minmax_acc.sv
// Running max/min accumulator; nxt_* expose the values including the sample
// presented this cycle so the controller can report without an extra stage.
module vib_minmax_acc #(
   parameter int DW = vib_pkg::VIB_DW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          load,
   input  logic          upd,
   input  logic [DW-1:0] dat,
   output logic [DW-1:0] nxt_max,
   output logic [DW-1:0] nxt_min
);

   logic [DW-1:0] run_max;
   logic [DW-1:0] run_min;

   always_comb begin
      nxt_max = (dat > run_max) ? dat : run_max;
      nxt_min = (dat < run_min) ? dat : run_min;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run_max <= '0;
         run_min <= '1;
      end else if (clr) begin
         run_max <= '0;
         run_min <= '1;
      end else if (load) begin
         run_max <= dat;
         run_min <= dat;
      end else if (upd) begin
         run_max <= nxt_max;
         run_min <= nxt_min;
      end
   end

endmodule

// File: rtl/vib_window_ctrl.sv
// Windowed max/min tracker: collects WIN_LEN valid samples per window and
// reports the extremes with a one-cycle dat_limit_en pulse.
module vib_window_ctrl
   import vib_pkg::*;
#(
   parameter int WIN_LEN = VIB_WIN_LEN_DEF,
   parameter int DW      = VIB_DW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          enable,
   input  logic          smp_valid,
   input  logic [DW-1:0] smp_dat,
   output logic [DW-1:0] dat_max,
   output logic [DW-1:0] dat_min,
   output logic          dat_limit_en,
   output logic [15:0]   win_cnt,
   output logic          busy
);

   localparam logic [15:0] LAST_CNT = 16'(WIN_LEN - 1);

   vib_state_e    state;
   logic [15:0]   smp_cnt;
   logic          acc_clr;
   logic          acc_load;
   logic          acc_upd;
   logic [DW-1:0] nxt_max;
   logic [DW-1:0] nxt_min;

   // A window starts on the first sample seen in FIRST or in REPORT, so the
   // sample arriving during the report cycle is never dropped.
   always_comb begin
      acc_clr  = !enable;
      acc_load = enable && smp_valid && (state == ST_FIRST || state == ST_REPORT);
      acc_upd  = enable && smp_valid && (state == ST_COLLECT);
   end

   vib_minmax_acc #(.DW(DW)) u_acc (
      .clk     (clk),
      .rst     (rst),
      .clr     (acc_clr),
      .load    (acc_load),
      .upd     (acc_upd),
      .dat     (smp_dat),
      .nxt_max (nxt_max),
      .nxt_min (nxt_min)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         smp_cnt      <= '0;
         dat_max      <= '0;
         dat_min      <= '0;
         dat_limit_en <= 1'b0;
         win_cnt      <= '0;
         busy         <= 1'b0;
      end else begin
         dat_limit_en <= 1'b0;
         if (!enable) begin
            state   <= ST_IDLE;
            smp_cnt <= '0;
            busy    <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  state <= ST_FIRST;
                  busy  <= 1'b1;
               end
               ST_FIRST: begin
                  if (smp_valid) begin
                     smp_cnt <= 16'd1;
                     state   <= ST_COLLECT;
                  end
               end
               ST_COLLECT: begin
                  if (smp_valid) begin
                     smp_cnt <= smp_cnt + 16'd1;
                     // Last sample: publish extremes including it, so the
                     // outputs are valid while the pulse is high.
                     if (smp_cnt == LAST_CNT) begin
                        state        <= ST_REPORT;
                        dat_max      <= nxt_max;
                        dat_min      <= nxt_min;
                        dat_limit_en <= 1'b1;
                        if (win_cnt != 16'hFFFF) win_cnt <= win_cnt + 16'd1;
                     end
                  end
               end
               ST_REPORT: begin
                  if (smp_valid) begin
                     smp_cnt <= 16'd1;
                     state   <= ST_COLLECT;
                  end else begin
                     smp_cnt <= '0;
                     state   <= ST_FIRST;
                  end
               end
               default: begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: doc/vib_window_ctrl.md
VIB_WINDOW_CTRL -- requirements
Module: vib_window_ctrl

Interface
REQ-001 Parameter WIN_LEN, default 256, samples per measurement window; legal range 2..65535.
REQ-002 Parameter DW, default 16, sample width.
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 enable  input  1  level; 1 = run windows, 0 = abort and idle.
REQ-006 smp_valid  input  1  one-cycle qualifier for smp_dat.
REQ-007 smp_dat  input  DW  unsigned vibration sample.
REQ-008 dat_max  output  DW  maximum of the last completed window.
REQ-009 dat_min  output  DW  minimum of the last completed window.
REQ-010 dat_limit_en  output  1  one-cycle pulse: dat_max/dat_min are newly valid.
REQ-011 win_cnt  output  16  completed-window count, saturating at 16'hFFFF.
REQ-012 busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-013 FSM states: IDLE, FIRST, COLLECT, REPORT.
REQ-014 IDLE -> FIRST when enable=1; any state -> IDLE when enable=0, taking effect the next cycle.
REQ-015 FIRST: on smp_valid, load run_max=run_min=smp_dat, set smp_cnt=1, go to COLLECT.
REQ-016 COLLECT: on smp_valid, run_max=max(run_max,smp_dat), run_min=min(run_min,smp_dat), and smp_cnt increments.
REQ-017 COLLECT: the sample that makes smp_cnt reach WIN_LEN is included in run_max/run_min; go to REPORT the next cycle.
REQ-018 REPORT lasts exactly one cycle: dat_max<=run_max, dat_min<=run_min, dat_limit_en=1, win_cnt increments unless saturated.
REQ-019 REPORT: a smp_valid in that cycle is the first sample of the next window (load run_max/run_min, smp_cnt=1) and the FSM goes to COLLECT; otherwise it goes to FIRST. No sample is lost.
REQ-020 dat_limit_en is registered, is high only in the REPORT cycle, and is always followed by at least one low cycle (guaranteed by WIN_LEN>=2).
REQ-021 dat_max and dat_min hold their value between REPORT cycles and are unchanged by aborts.
REQ-022 Comparisons are unsigned, DW bits; dat_max>=dat_min always holds after any REPORT.
REQ-023 Equal samples across a window give dat_max==dat_min.
REQ-024 enable=0 mid-window discards the partial window: no REPORT, smp_cnt cleared, win_cnt held.
REQ-025 enable=0 during the REPORT cycle: the REPORT completes (pulse issued) and the FSM goes to IDLE.
REQ-026 smp_valid in IDLE is ignored.
REQ-027 smp_cnt width is 16 bits; it never exceeds WIN_LEN.
REQ-028 Latency from the last window sample (smp_valid edge) to dat_limit_en high is 1 clock.

Reset
REQ-029 Asynchronous assertion of rst forces FSM=IDLE, dat_max=0, dat_min=0, dat_limit_en=0, win_cnt=0, busy=0, smp_cnt=0, run_max=0, run_min=all-ones.
REQ-030 After rst deasserts, the first FSM transition occurs on the first posedge with enable=1.
REQ-031 rst asserted mid-window discards the partial window with no dat_limit_en pulse.

Structure
REQ-032 The FSM state enum and the default WIN_LEN/DW constants are defined in shared package vib_pkg.
REQ-033 One sub-module, vib_minmax_acc (running max/min with load/update controls), is instantiated once.
REQ-034 The dat_max/dat_min/dat_limit_en outputs connect directly to the existing alarm judgement block's same-named inputs.

Verification
REQ-035 WIN_LEN=4, enable=1, samples 10,50,20,30 -> one pulse, dat_max=50, dat_min=10, win_cnt=1.
REQ-036 WIN_LEN=4, continuous smp_valid 1..8 -> pulses one cycle after samples 4 and 8; windows (4,1) then (8,5); no sample dropped.
REQ-037 Apply samples 0xFFFF, 0x0000, 0x8000, 0x8000 -> dat_max=0xFFFF, dat_min=0x0000.
REQ-038 enable=0 after 2 of 4 samples, re-enable, then 4 samples of 7 -> exactly one pulse, dat_max=dat_min=7, win_cnt=1.
REQ-039 Pulse rst asynchronously (between clock edges) mid-window -> outputs zero immediately, no pulse, busy=0.
REQ-040 Force win_cnt near saturation, run 2 windows -> win_cnt holds at 0xFFFF.
